// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, MIPS opcode/funct constants and the decoded-instruction bundle shared by decode, issue and ALU
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLL  = 4'h2;
  localparam logic [3:0] ALU_SRL  = 4'h3;
  localparam logic [3:0] ALU_SLT  = 4'h4;
  localparam logic [3:0] ALU_AND  = 4'h5;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_XOR  = 4'h7;
  localparam logic [3:0] ALU_SLTU = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'h9;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
  typedef enum logic [1:0] {SEL1_ZERO, SEL1_RS, SEL1_SHAMT, SEL1_SIXTEEN} sel1_t;
  typedef enum logic [1:0] {SEL2_ZERO, SEL2_RT, SEL2_SIMM, SEL2_ZIMM} sel2_t;
  typedef struct packed {
    logic [3:0] ctrl;
    sel1_t      sel1;
    sel2_t      sel2;
    logic [4:0] dest;
    logic       illegal;
  } dec_t;
  localparam dec_t DEC_ILLEGAL = '{ctrl: ALU_ADD, sel1: SEL1_ZERO, sel2: SEL2_ZERO, dest: 5'd0, illegal: 1'b1};
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational MIPS ALU-instruction decode
// ports: instr (32-bit MIPS word) in; dec (ctrl, operand selects, dest, illegal) out
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);
  logic unused_fields;
  assign unused_fields = ^{instr[25:21], instr[10:6]};
  function automatic dec_t itype(input logic [3:0] c, input sel2_t s, input logic [4:0] rt);
    return '{ctrl: c, sel1: SEL1_RS, sel2: s, dest: rt, illegal: 1'b0};
  endfunction
  always_comb begin
    dec = DEC_ILLEGAL;
    case (instr[31:26])
      OP_RTYPE: begin
        dec = '{ctrl: ALU_ADD, sel1: SEL1_RS, sel2: SEL2_RT, dest: instr[15:11], illegal: 1'b0};
        case (instr[5:0])
          F_ADD, F_ADDU: dec.ctrl = ALU_ADD;
          F_SUB, F_SUBU: dec.ctrl = ALU_SUB;
          F_AND:  dec.ctrl = ALU_AND;
          F_OR:   dec.ctrl = ALU_OR;
          F_XOR:  dec.ctrl = ALU_XOR;
          F_SLT:  dec.ctrl = ALU_SLT;
          F_SLTU: dec.ctrl = ALU_SLTU;
          F_SLLV: dec.ctrl = ALU_SLL;
          F_SRLV: dec.ctrl = ALU_SRL;
          F_SRAV: dec.ctrl = ALU_SRA;
          F_SLL: begin dec.ctrl = ALU_SLL; dec.sel1 = SEL1_SHAMT; end
          F_SRL: begin dec.ctrl = ALU_SRL; dec.sel1 = SEL1_SHAMT; end
          F_SRA: begin dec.ctrl = ALU_SRA; dec.sel1 = SEL1_SHAMT; end
          default: dec = DEC_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ADDIU: dec = itype(ALU_ADD, SEL2_SIMM, instr[20:16]);
      OP_SLTI:  dec = itype(ALU_SLT, SEL2_SIMM, instr[20:16]);
      OP_SLTIU: dec = itype(ALU_SLTU, SEL2_SIMM, instr[20:16]);
      OP_ANDI:  dec = itype(ALU_AND, SEL2_ZIMM, instr[20:16]);
      OP_ORI:   dec = itype(ALU_OR, SEL2_ZIMM, instr[20:16]);
      OP_XORI:  dec = itype(ALU_XOR, SEL2_ZIMM, instr[20:16]);
      // lui is issued as imm << 16
      OP_LUI:   dec = '{ctrl: ALU_SLL, sel1: SEL1_SIXTEEN, sel2: SEL2_ZIMM, dest: instr[20:16], illegal: 1'b0};
      default:  dec = DEC_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: ID->EX issue register for the ALU with operand select, optional forwarding and issue counter
// ports: clk, rst_n (sync, active-low); id_valid/id_instr/id_rs_data/id_rt_data decode slot;
//   stall holds, flush kills; ex_* registered ALU command; issue_count counts legal issues.
// macro ALU_ISSUE_FWD_EN adds fwd_em_*/fwd_mw_* bypass inputs for register-sourced operands.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
`ifdef ALU_ISSUE_FWD_EN
  input  logic        fwd_em_we,
  input  logic [4:0]  fwd_em_reg,
  input  logic [31:0] fwd_em_data,
  input  logic        fwd_mw_we,
  input  logic [4:0]  fwd_mw_reg,
  input  logic [31:0] fwd_mw_data,
`endif
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_in1,
  output logic [31:0] ex_in2,
  output logic [3:0]  ex_ctrl_alu,
  output logic [4:0]  ex_wr_reg,
  output logic        ex_reg_we,
  output logic        ex_illegal,
  output logic [31:0] issue_count
);
  dec_t dec;
  logic [31:0] rs_val, rt_val, in1, in2;
  alu_decode u_dec (.instr(id_instr), .dec(dec));
`ifdef ALU_ISSUE_FWD_EN
  // EM is younger than MW, so it wins; $0 is never bypassed
  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] d);
    return idx == 5'd0 ? d : fwd_em_we && fwd_em_reg == idx ? fwd_em_data :
           fwd_mw_we && fwd_mw_reg == idx ? fwd_mw_data : d;
  endfunction
  assign rs_val = fwd(id_instr[25:21], id_rs_data);
  assign rt_val = fwd(id_instr[20:16], id_rt_data);
`else
  assign rs_val = id_rs_data;
  assign rt_val = id_rt_data;
`endif
  assign in1 = dec.sel1 == SEL1_RS ? rs_val : dec.sel1 == SEL1_SHAMT ? {27'd0, id_instr[10:6]} :
               dec.sel1 == SEL1_SIXTEEN ? 32'd16 : 32'd0;
  assign in2 = dec.sel2 == SEL2_RT ? rt_val : dec.sel2 == SEL2_SIMM ? {{16{id_instr[15]}}, id_instr[15:0]} :
               dec.sel2 == SEL2_ZIMM ? {16'd0, id_instr[15:0]} : 32'd0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_reg_we   <= 1'b0;
      ex_illegal  <= 1'b0;
      ex_in1      <= '0;
      ex_in2      <= '0;
      ex_ctrl_alu <= '0;
      ex_wr_reg   <= '0;
      issue_count <= '0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_reg_we  <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (!stall) begin
      ex_valid    <= id_valid;
      ex_reg_we   <= id_valid && !dec.illegal && dec.dest != 5'd0;
      ex_illegal  <= id_valid && dec.illegal;
      ex_in1      <= in1;
      ex_in2      <= in2;
      ex_ctrl_alu <= dec.ctrl;
      ex_wr_reg   <= dec.dest;
      issue_count <= issue_count + {31'd0, id_valid && !dec.illegal};
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized scoreboard bench for alu_issue against a behavioural MIPS decode model
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, id_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] id_instr = '0, id_rs_data = '0, id_rt_data = '0;
  logic        fwd_em_we = 1'b0, fwd_mw_we = 1'b0;
  logic [4:0]  fwd_em_reg = '0, fwd_mw_reg = '0;
  logic [31:0] fwd_em_data = '0, fwd_mw_data = '0;
  logic        ex_valid, ex_reg_we, ex_illegal;
  logic [31:0] ex_in1, ex_in2, issue_count;
  logic [3:0]  ex_ctrl_alu;
  logic [4:0]  ex_wr_reg;
  int n_chk = 0, n_pass = 0;
  typedef struct {
    logic valid, we, ill;
    logic [31:0] in1, in2, cnt;
    logic [3:0] ctrl;
    logic [4:0] wr;
    bit ill_known, data_known, wr_known;
  } exp_t;
  exp_t cur, sb[$];
  logic [5:0] fns [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B,
                           6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  logic [5:0] ops [9] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3F};

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
`ifdef ALU_ISSUE_FWD_EN
    .fwd_em_we(fwd_em_we), .fwd_em_reg(fwd_em_reg), .fwd_em_data(fwd_em_data),
    .fwd_mw_we(fwd_mw_we), .fwd_mw_reg(fwd_mw_reg), .fwd_mw_data(fwd_mw_data),
`endif
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2),
    .ex_ctrl_alu(ex_ctrl_alu), .ex_wr_reg(ex_wr_reg), .ex_reg_we(ex_reg_we),
    .ex_illegal(ex_illegal), .issue_count(issue_count));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] d);
`ifdef ALU_ISSUE_FWD_EN
    if (idx != 0 && fwd_em_we && fwd_em_reg == idx) return fwd_em_data;
    if (idx != 0 && fwd_mw_we && fwd_mw_reg == idx) return fwd_mw_data;
`endif
    return d;
  endfunction

  // MIPS semantics: which ALU op, what goes on each input, who is written
  task automatic ref_decode(input logic [31:0] w, output bit ok, output logic [3:0] c,
                            output logic [31:0] a, output logic [31:0] b, output logic [4:0] d);
    logic [31:0] se, ze, sh, rsv, rtv;
    se = {{16{w[15]}}, w[15:0]};
    ze = {16'd0, w[15:0]};
    sh = {27'd0, w[10:6]};
    rsv = fwd(w[25:21], id_rs_data);
    rtv = fwd(w[20:16], id_rt_data);
    ok = 1; c = 0; a = rsv; b = rtv; d = w[20:16];
    if (w[31:26] == 6'h00) begin
      d = w[15:11];
      case (w[5:0])
        6'h20, 6'h21: c = 0;
        6'h22, 6'h23: c = 1;
        6'h24: c = 5;
        6'h25: c = 6;
        6'h26: c = 7;
        6'h2A: c = 4;
        6'h2B: c = 8;
        6'h00: begin c = 2; a = sh; end
        6'h02: begin c = 3; a = sh; end
        6'h03: begin c = 9; a = sh; end
        6'h04: c = 2;
        6'h06: c = 3;
        6'h07: c = 9;
        default: ok = 0;
      endcase
    end else begin
      case (w[31:26])
        6'h08, 6'h09: b = se;
        6'h0A: begin c = 4; b = se; end
        6'h0B: begin c = 8; b = se; end
        6'h0C: begin c = 5; b = ze; end
        6'h0D: begin c = 6; b = ze; end
        6'h0E: begin c = 7; b = ze; end
        6'h0F: begin c = 2; a = 16; b = ze; end
        default: ok = 0;
      endcase
    end
  endtask

  task automatic model();
    bit ok;
    logic [3:0] c;
    logic [31:0] a, b;
    logic [4:0] d;
    if (!rst_n) begin
      cur = '{valid: 0, we: 0, ill: 0, in1: 0, in2: 0, cnt: 0, ctrl: 0, wr: 0,
              ill_known: 1, data_known: 1, wr_known: 1};
    end else if (flush) begin
      cur.valid = 0; cur.we = 0; cur.ill = 0; cur.ill_known = 1;
      cur.data_known = 0; cur.wr_known = 0;
    end else if (!stall) begin
      if (!id_valid) begin
        cur.valid = 0; cur.we = 0; cur.ill_known = 0; cur.data_known = 0; cur.wr_known = 0;
      end else begin
        ref_decode(id_instr, ok, c, a, b, d);
        cur.valid = 1; cur.ill = !ok; cur.ill_known = 1; cur.we = ok && d != 0;
        cur.ctrl = ok ? c : 4'd0; cur.in1 = ok ? a : 32'd0; cur.in2 = ok ? b : 32'd0;
        cur.wr = d; cur.wr_known = ok; cur.data_known = 1;
        cur.cnt = cur.cnt + (ok ? 32'd1 : 32'd0);
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] w, input logic [31:0] a,
                      input logic [31:0] b, input logic st, input logic fl);
    rst_n = r; id_valid = v; id_instr = w; id_rs_data = a; id_rt_data = b; stall = st; flush = fl;
    model();
    sb.push_back(cur);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0, 1, 2, 3: begin w[31:26] = 6'h00; w[5:0] = fns[$urandom_range(0, 14)]; end
      4, 5, 6, 7: w[31:26] = ops[$urandom_range(0, 8)];
      default: ;
    endcase
    return w;
  endfunction

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
      chk("ex_reg_we", {31'd0, ex_reg_we}, {31'd0, e.we});
      chk("issue_count", issue_count, e.cnt);
      if (e.ill_known) chk("ex_illegal", {31'd0, ex_illegal}, {31'd0, e.ill});
      if (e.data_known) begin
        chk("ex_in1", ex_in1, e.in1);
        chk("ex_in2", ex_in2, e.in2);
        chk("ex_ctrl_alu", {28'd0, ex_ctrl_alu}, {28'd0, e.ctrl});
      end
      if (e.wr_known) chk("ex_wr_reg", {27'd0, ex_wr_reg}, {27'd0, e.wr});
    end
  end

  initial begin
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h2025FFFD, 1, 2, 1, 1);
    chk("rst_valid", {31'd0, ex_valid}, 0);
    chk("rst_count", issue_count, 0);
    chk("rst_in1", ex_in1, 0);
    step(1, 1, 32'h2025FFFD, 10, 7, 0, 0);
    chk("addi_ctrl", {28'd0, ex_ctrl_alu}, 0);
    chk("addi_in1", ex_in1, 10);
    chk("addi_in2", ex_in2, 32'hFFFFFFFD);
    chk("addi_wr", {27'd0, ex_wr_reg}, 5);
    chk("addi_we", {31'd0, ex_reg_we}, 1);
    step(1, 1, 32'h00021903, 5, 32'h80000000, 0, 0);
    chk("sra_ctrl", {28'd0, ex_ctrl_alu}, 9);
    chk("sra_in1", ex_in1, 4);
    chk("sra_in2", ex_in2, 32'h80000000);
    chk("sra_wr", {27'd0, ex_wr_reg}, 3);
    step(1, 1, 32'h3C071234, 32'hDEAD, 32'hBEEF, 0, 0);
    chk("lui_ctrl", {28'd0, ex_ctrl_alu}, 2);
    chk("lui_in1", ex_in1, 16);
    chk("lui_in2", ex_in2, 32'h00001234);
    step(1, 1, 32'h34200005, 1, 2, 0, 0);
    chk("ori0_we", {31'd0, ex_reg_we}, 0);
    step(1, 1, 32'hFC000000, 1, 2, 0, 0);
    chk("ill_flag", {31'd0, ex_illegal}, 1);
    chk("ill_we", {31'd0, ex_reg_we}, 0);
    chk("ill_count", issue_count, 4);
    step(1, 1, 32'h2025FFFD, 10, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 32'h00021903, 99, 99, 1, 0);
      chk("stall_in1", ex_in1, 10);
      chk("stall_count", issue_count, 5);
    end
    step(1, 1, 32'h00021903, 99, 99, 1, 1);
    chk("stflush_valid", {31'd0, ex_valid}, 0);
    step(1, 1, 32'h2025FFFD, 10, 0, 0, 0);
    step(1, 1, 32'h00021903, 99, 99, 1, 0);
    step(0, 1, 32'h00021903, 99, 99, 1, 0);
    chk("rststall_valid", {31'd0, ex_valid}, 0);
    chk("rststall_in1", ex_in1, 0);
    chk("rststall_in2", ex_in2, 0);
    chk("rststall_count", issue_count, 0);
    step(1, 0, 0, 0, 0, 0, 0);
`ifdef ALU_ISSUE_FWD_EN
    fwd_em_we = 1; fwd_em_reg = 4; fwd_em_data = 32'hAA;
    fwd_mw_we = 1; fwd_mw_reg = 4; fwd_mw_data = 32'hBB;
    step(1, 1, 32'h00800820, 32'h55, 1, 0, 0);
    chk("fwd_em_wins", ex_in1, 32'hAA);
    step(1, 1, 32'h00000820, 32'h55, 1, 0, 0);
    chk("fwd_r0", ex_in1, 32'h55);
    fwd_em_we = 0; fwd_mw_we = 0;
`endif
    for (int i = 0; i < 400; i++) begin
      fwd_em_we = 1'($urandom); fwd_em_reg = 5'($urandom_range(0, 7)); fwd_em_data = $urandom;
      fwd_mw_we = 1'($urandom); fwd_mw_reg = 5'($urandom_range(0, 7)); fwd_mw_data = $urandom;
      step($urandom_range(0, 49) != 0, $urandom_range(0, 4) != 0, rand_instr(), $urandom, $urandom,
           $urandom_range(0, 6) == 0, $urandom_range(0, 14) == 0);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
